// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bundle for mem_stage: upstream pipeline fields in, registered write-back
// fields and the upstream stall out.
interface mem_stage_if;
  logic [31:0] instructionin;
  logic [31:0] addressin;
  logic [31:0] aluin;
  logic [31:0] datain;
  logic [31:0] instructionout;
  logic [31:0] addressout;
  logic [31:0] aluout;
  logic [31:0] memout;
  logic        misalign;
  logic        stall;

  modport master (
    output instructionin, addressin, aluin, datain,
    input  instructionout, addressout, aluout, memout, misalign, stall
  );

  modport slave (
    input  instructionin, addressin, aluin, datain,
    output instructionout, addressout, aluout, memout, misalign, stall
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB register and a fixed-latency word-organised data memory.
// Optional misaligned-access trap is enabled by defining MEMSTAGE_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
  localparam logic        MULTI = (MEM_LATENCY > 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpSw  = 6'h2B;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [5:0]      opcode;
  logic            is_load, is_store, is_mem;
  logic            trap;
  logic [AW-1:0]   word_idx;
  logic [31:0]     rd_word, wr_word, load_val;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            start_busy, stall_int, mem_we;
  logic            unused_addr;

  assign opcode      = bus.instructionin[31:26];
  assign word_idx    = bus.aluin[AW+1:2];
  assign unused_addr = ^bus.aluin[31:AW+2];
  assign rd_word     = mem[word_idx];

  always_comb begin
    is_load  = (opcode == OpLw) || (opcode == OpLb) || (opcode == OpLbu) ||
               (opcode == OpLh) || (opcode == OpLhu);
    is_store = (opcode == OpSw) || (opcode == OpSb) || (opcode == OpSh);
    is_mem   = is_load || is_store;
  end

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  always_comb begin
    trap = (((opcode == OpLw) || (opcode == OpSw)) && (bus.aluin[1:0] != 2'b00)) ||
           (((opcode == OpLh) || (opcode == OpLhu) || (opcode == OpSh)) && bus.aluin[0]);
  end
`else
  assign trap = 1'b0;
`endif

  // Lane extraction; without the trap, low bits below the access size are simply dropped.
  always_comb begin
    ld_byte  = rd_word[{bus.aluin[1:0], 3'b000} +: 8];
    ld_half  = bus.aluin[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = 32'h0;
    case (opcode)
      OpLw:    load_val = rd_word;
      OpLb:    load_val = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   load_val = {24'h0, ld_byte};
      OpLh:    load_val = {{16{ld_half[15]}}, ld_half};
      OpLhu:   load_val = {16'h0, ld_half};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    wr_word = rd_word;
    case (opcode)
      OpSw: wr_word = bus.datain;
      OpSh: begin
        if (bus.aluin[1]) wr_word[31:16] = bus.datain[15:0];
        else              wr_word[15:0]  = bus.datain[15:0];
      end
      OpSb:    wr_word[{bus.aluin[1:0], 3'b000} +: 8] = bus.datain[7:0];
      default: wr_word = rd_word;
    endcase
  end

  assign start_busy = (state_q == StIdle) && is_mem && !trap && MULTI;
  assign stall_int  = !reset && (start_busy || ((state_q == StBusy) && (cnt_q != '0)));
  assign mem_we     = !reset && !stall_int && is_store && !trap;
  assign bus.stall  = stall_int;

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      bus.instructionout <= 32'h0;
      bus.addressout     <= 32'h0;
      bus.aluout         <= 32'h0;
      bus.memout         <= 32'h0;
      bus.misalign       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_busy) begin
            state_q <= StBusy;
            cnt_q   <= CNT_LOAD;
          end
        end
        StBusy: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - CW'(1);
          else             state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Stalled edges emit a bubble so write-back never sees the op twice.
      if (stall_int) begin
        bus.instructionout <= 32'h0;
        bus.addressout     <= 32'h0;
        bus.aluout         <= 32'h0;
        bus.memout         <= 32'h0;
        bus.misalign       <= 1'b0;
      end else begin
        bus.instructionout <= bus.instructionin;
        bus.addressout     <= bus.addressin;
        bus.aluout         <= bus.aluin;
        bus.memout         <= (is_load && !trap) ? load_val : 32'h0;
        bus.misalign       <= trap;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage at the default parameters (MEM_LATENCY = 2).
module tb_mem_stage;

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  localparam logic [5:0] OpLw = 6'h23, OpLb = 6'h20, OpLbu = 6'h24, OpLh = 6'h21;
  localparam logic [5:0] OpLhu = 6'h25, OpSw = 6'h2B, OpSb = 6'h28, OpSh = 6'h29;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] data;
    logic [31:0] exp_mem;
    logic        exp_mis;
    int          exp_stalls;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_stage_if bus();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [5:0] op);
    return {op, 26'h0A51234};
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] alu,
                              input logic [31:0] data, input logic [31:0] exp_mem,
                              input logic exp_mis, input int exp_stalls);
    vec_t v;
    v.instr = ins(op); v.alu = alu; v.data = data;
    v.exp_mem = exp_mem; v.exp_mis = exp_mis; v.exp_stalls = exp_stalls;
    return v;
  endfunction

  // Presents one op at a negedge, counts stalled edges, leaves the sample point 1ns past
  // the completion edge.
  task automatic run_op(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] data, output int nst);
    @(negedge clk);
    bus.instructionin = instr;
    bus.addressin     = pc;
    bus.aluin         = alu;
    bus.datain        = data;
    #1;
    nst = 0;
    while (bus.stall && nst < 8) begin
      @(posedge clk);
      #1;
      chk("bubble", bus.instructionout | bus.addressout | bus.aluout | bus.memout |
          {31'h0, bus.misalign}, 32'h0);
      nst++;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[$];
  logic [31:0] exp40;
  int          nst;
  logic [31:0] pc;

  initial begin
    exp40 = Trap ? 32'hCAFEF00D : 32'h12345678;
    vecs.push_back(mk(OpSw,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1));
    vecs.push_back(mk(OpLw,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1));
    vecs.push_back(mk(OpSw,  32'h20,  32'h11223344, 32'h0,        1'b0, 1));
    vecs.push_back(mk(OpSb,  32'h21,  32'h123456AA, 32'h0,        1'b0, 1));
    vecs.push_back(mk(OpLw,  32'h20,  32'h0,        32'h1122AA44, 1'b0, 1));
    vecs.push_back(mk(OpSw,  32'h30,  32'h0,        32'h0,        1'b0, 1));
    vecs.push_back(mk(OpSb,  32'h30,  32'hFFFFFF80, 32'h0,        1'b0, 1));
    vecs.push_back(mk(OpSh,  32'h32,  32'hABCD8001, 32'h0,        1'b0, 1));
    vecs.push_back(mk(OpLb,  32'h30,  32'h0,        32'hFFFFFF80, 1'b0, 1));
    vecs.push_back(mk(OpLbu, 32'h30,  32'h0,        32'h00000080, 1'b0, 1));
    vecs.push_back(mk(OpLh,  32'h32,  32'h0,        32'hFFFF8001, 1'b0, 1));
    vecs.push_back(mk(OpLhu, 32'h32,  32'h0,        32'h00008001, 1'b0, 1));
    vecs.push_back(mk(OpLb,  32'h33,  32'h0,        32'hFFFFFF80, 1'b0, 1));
    vecs.push_back(mk(OpLbu, 32'h31,  32'h0,        32'h0,        1'b0, 1));
    vecs.push_back(mk(6'h00, 32'h5,   32'h77,       32'h0,        1'b0, 0));
    vecs.push_back(mk(OpLw,  32'h410, 32'h0,        32'hDEADBEEF, 1'b0, 1));
    vecs.push_back(mk(OpSw,  32'h40,  32'hCAFEF00D, 32'h0,        1'b0, 1));
    vecs.push_back(mk(OpSw,  32'h42,  32'h12345678, 32'h0,        Trap, Trap ? 0 : 1));
    vecs.push_back(mk(OpLw,  32'h40,  32'h0,        exp40,        1'b0, 1));
    vecs.push_back(mk(OpLh,  32'h31,  32'h0,        Trap ? 32'h0 : 32'h00000080, Trap,
                      Trap ? 0 : 1));

    // Reset state, with a memory op presented to show stall is forced low.
    bus.instructionin = ins(OpLw);
    bus.addressin     = 32'h4;
    bus.aluin         = 32'h10;
    bus.datain        = 32'h0;
    #1;
    chk("reset_stall", {31'h0, bus.stall}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_instr", bus.instructionout, 32'h0);
    chk("reset_addr", bus.addressout, 32'h0);
    chk("reset_alu", bus.aluout, 32'h0);
    chk("reset_mem", bus.memout, 32'h0);
    chk("reset_mis", {31'h0, bus.misalign}, 32'h0);
    @(negedge clk);
    reset             = 1'b0;
    bus.instructionin = 32'h0;

    for (int i = 0; i < vecs.size(); i++) begin
      pc = 32'h1000 + 32'(4 * i);
      run_op(vecs[i].instr, pc, vecs[i].alu, vecs[i].data, nst);
      chk($sformatf("v%0d_stalls", i), 32'(nst), 32'(vecs[i].exp_stalls));
      chk($sformatf("v%0d_instr", i), bus.instructionout, vecs[i].instr);
      chk($sformatf("v%0d_addr", i), bus.addressout, pc);
      chk($sformatf("v%0d_alu", i), bus.aluout, vecs[i].alu);
      chk($sformatf("v%0d_mem", i), bus.memout, vecs[i].exp_mem);
      chk($sformatf("v%0d_mis", i), {31'h0, bus.misalign}, {31'h0, vecs[i].exp_mis});
    end

    // Reset during the BUSY cycle of a store: store aborted, outputs cleared.
    @(negedge clk);
    bus.instructionin = ins(OpSw);
    bus.addressin     = 32'h2000;
    bus.aluin         = 32'h40;
    bus.datain        = 32'hBAD0BAD0;
    #1;
    chk("abort_stall_idle", {31'h0, bus.stall}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_stall_rst", {31'h0, bus.stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("abort_instr", bus.instructionout, 32'h0);
    chk("abort_mem", bus.memout, 32'h0);
    chk("abort_alu", bus.aluout, 32'h0);
    @(negedge clk);
    reset             = 1'b0;
    bus.instructionin = 32'h0;
    run_op(ins(OpLw), 32'h2004, 32'h40, 32'h0, nst);
    chk("abort_lw_stalls", 32'(nst), 32'h1);
    chk("abort_lw_mem", bus.memout, exp40);

    // Non-memory op never raises stall.
    @(negedge clk);
    bus.instructionin = 32'h00221820;
    bus.aluin         = 32'h5;
    #1;
    chk("nop_stall", {31'h0, bus.stall}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage with its MEM/WB output register. It sits directly downstream of the EX/MEM register and consumes its instruction, PC+4, ALU result and store data. It performs loads and stores on an internal word-organised data memory with a fixed multi-cycle access latency, stalling upstream while an access is in flight. It registers the results toward write-back.

## Interface
- DEPTH_WORDS, 256: data memory depth in 32-bit words; power of two, minimum 4.
- MEM_LATENCY, 2: cycles per memory access, minimum 1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instructionin  in  32  instruction from EX/MEM; opcode is [31:26].
- addressin  in  32  PC+4 from EX/MEM.
- aluin  in  32  ALU result; the effective address for memory ops.
- datain  in  32  store data (rt value).
- instructionout  out  32  registered instruction to write-back; 0 is a bubble.
- addressout  out  32  registered PC+4.
- aluout  out  32  registered ALU result.
- memout  out  32  registered load result, extended to 32 bits.
- misalign  out  1  registered flag: the accompanying instruction was a misaligned access.
- stall  out  1  combinational; high means upstream must hold EX/MEM contents unchanged.

## Operation
- Opcode decode:
  - Loads: LW 0x23, LB 0x20, LBU 0x24, LH 0x21, LHU 0x25.
  - Stores: SW 0x2B, SB 0x28, SH 0x29.
  - Any other opcode is a non-memory op.
- Addressing:
  - Word index = aluin[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap.
  - Byte lanes are little-endian: aluin[1:0]=0 selects bits [7:0]; halfword aluin[1]=0 selects bits [15:0].
- Load extension: LB and LH sign-extend; LBU and LHU zero-extend; LW is unmodified. memout = 0 for stores and non-memory ops.
- Stores: SB and SH write only their addressed lanes; the other lanes are preserved.
- FSM states:
  - IDLE to BUSY: a memory op is present and MEM_LATENCY > 1. The counter is loaded with MEM_LATENCY-2.
  - BUSY, counter ≠ 0: decrement the counter.
  - BUSY, counter = 0: complete the access and return to IDLE.
- Stall: stall = (IDLE and memory op and MEM_LATENCY>1) or BUSY, except on the completing cycle, where stall = 0.
- Completion edge:
  - The store write happens exactly once, on this edge.
  - Load data is captured into memout on this edge.
  - All outputs load from the inputs on this edge.
- Stalled edges: instructionout, addressout, aluout, memout and misalign load 0 (a bubble), so write-back never sees a duplicate.
- Non-memory op: single cycle, never stalls. Outputs load the inputs on the next edge.
- Reset:
  - Reset wins over everything, including mid-access.
  - FSM goes to IDLE and the counter to 0.
  - All outputs go to 0; stall is forced to 0 while reset is high.
  - Memory contents are not reset.
  - An aborted store does not write.

## Timing
- Reset values: instructionout, addressout, aluout and memout = 32'h0; misalign = 0; stall = 0.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: exactly MEM_LATENCY cycles from the first presentation to outputs valid, with stall high for MEM_LATENCY-1 cycles.
- MEM_LATENCY=1: every op completes in 1 cycle and stall is constantly 0.
- Back-to-back memory ops: the second op starts from IDLE on the cycle after the first completes. No idle gap is required.
- Load after store to the same word: the load returns the newly written data, because the write commits on the store's completion edge and the load reads on a later edge.
- Inputs are sampled only on the completion edge. Values present during stalled cycles are ignored.

## Configuration
- MEMSTAGE_MISALIGN_TRAP_EN defined:
  - Misaligned conditions: LW or SW with aluin[1:0] ≠ 0; LH, LHU or SH with aluin[0] ≠ 0.
  - A misaligned op completes in 1 cycle with no stall and no memory write.
  - memout = 0 and misalign = 1 with the instruction.
- Not defined:
  - Low address bits below the access size are ignored and the access is forced aligned.
  - misalign is tied to 0.

## Test plan
- Reset, then LW with aluin=0x10 and memory word 4 = 0xDEADBEEF, MEM_LATENCY=2 → stall high for 1 cycle; bubble on the first edge; memout=0xDEADBEEF on the second edge.
- SW with datain=0x11223344 to 0x20, then SB with datain=0xAA to 0x21, then LW from 0x20 → memout=0x1122AA44.
- LB from byte 0x80 → memout=0xFFFFFF80; LBU from the same byte → 0x00000080; LH from halfword 0x8001 → 0xFFFF8001.
- Non-memory instruction (opcode 0x00, aluin=0x5) → outputs on the next edge, aluout=0x5, stall never high.
- Reset asserted during the BUSY cycle of an SW to 0x40 → all outputs 0, FSM in IDLE, word 0x40 unchanged.
- With MEMSTAGE_MISALIGN_TRAP_EN defined, SW to 0x42 → misalign=1 after 1 cycle, no stall, word 0x40 unchanged. Without the macro, the same SW writes word 0x40.
